ascii_to_binary: RTL and testbench

ASCII_TO_BINARY -- requirements
Module: ascii_to_binary

---
 rtl/ascii_to_binary.sv | 148 ++++++++++++++
 tb/tb_ascii_to_binary.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_to_binary.sv
// Decimal ASCII field to unsigned binary converter. A field is a run of digits
// ended by SOH (0x01); the result and status are published with a done pulse.
//
// state   | meaning
// IDLE    | waiting for start_i
// ACCUM   | consuming bytes, accumulating digits
// DONE    | one-cycle result pulse
module ascii_to_binary #(
  parameter int BITS_OUT_PP          = 32,
  parameter int DIGITS_IN_PP         = 10,
  parameter int DIGIT_COUNT_WIDTH_PP = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            ce_i,
  input  logic                            start_i,
  input  logic [7:0]                      dat_ascii_i,
  input  logic                            dat_valid_i,
  output logic                            dat_ready_o,
  output logic [BITS_OUT_PP-1:0]          dat_binary_o,
  output logic [DIGIT_COUNT_WIDTH_PP-1:0] digits_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o
);

  localparam int ACC_W = BITS_OUT_PP + 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [BITS_OUT_PP-1:0]            acc_q, acc_d;
  logic [DIGIT_COUNT_WIDTH_PP-1:0]   cnt_q, cnt_d;
  logic                              err_q, err_d;
  logic [BITS_OUT_PP-1:0]            bin_q, bin_d;
  logic [DIGIT_COUNT_WIDTH_PP-1:0]   dig_q, dig_d;
  logic                              err_out_q, err_out_d;

  logic [ACC_W-1:0] acc_wide;
  logic [ACC_W-1:0] acc_mul;
  logic             is_digit;
  logic             is_soh;
  logic             take;
  logic             ovf;

  // acc*10 + digit as shift-and-add, widened so overflow shows in the top bits
  always_comb begin
    acc_wide = {4'b0000, acc_q};
    acc_mul  = (acc_wide << 3) + (acc_wide << 1)
             + {{(ACC_W-4){1'b0}}, dat_ascii_i[3:0]};
    is_digit = (dat_ascii_i >= 8'h30) && (dat_ascii_i <= 8'h39);
    is_soh   = (dat_ascii_i == 8'h01);
    take     = ce_i && dat_valid_i && (state_q == S_ACCUM);
    ovf      = (|acc_mul[ACC_W-1:BITS_OUT_PP])
            || (cnt_q == DIGIT_COUNT_WIDTH_PP'(DIGITS_IN_PP));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ce_i) begin
      case (state_q)
        S_IDLE:  if (start_i) state_d = S_ACCUM;
        S_ACCUM: if (dat_valid_i && is_soh) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    dat_ready_o = (state_q == S_ACCUM);
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
  end

  // Result registers load as SOH is consumed so they are valid alongside done_o
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    bin_d     = bin_q;
    dig_d     = dig_q;
    err_out_d = err_out_q;
    if (ce_i && (state_q == S_IDLE) && start_i) begin
      acc_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end else if (take) begin
      if (is_soh) begin
        if (err_q || (cnt_q == '0)) begin
          bin_d     = '0;
          dig_d     = '0;
          err_out_d = 1'b1;
        end else begin
          bin_d     = acc_q;
          dig_d     = cnt_q;
          err_out_d = 1'b0;
        end
      end else if (is_digit) begin
        if (!err_q) begin
          if (ovf) begin
            err_d = 1'b1;
          end else begin
            acc_d = acc_mul[BITS_OUT_PP-1:0];
            cnt_d = cnt_q + DIGIT_COUNT_WIDTH_PP'(1);
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      bin_q     <= '0;
      dig_q     <= '0;
      err_out_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      bin_q     <= bin_d;
      dig_q     <= dig_d;
      err_out_q <= err_out_d;
    end
  end

  assign dat_binary_o = bin_q;
  assign digits_o     = dig_q;
  assign err_o        = err_out_q;

endmodule

// File: tb/tb_ascii_to_binary.sv
// Bench for ascii_to_binary: directed and random fields checked every cycle
// against a field-level model, plus literal expectations for known fields.
module tb_ascii_to_binary;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  dat_ascii = 8'h00;
  logic        dat_valid = 1'b0;
  logic        dat_ready;
  logic [31:0] dat_binary;
  logic [3:0]  digits;
  logic        busy;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  ascii_to_binary #(
    .BITS_OUT_PP(32),
    .DIGITS_IN_PP(10),
    .DIGIT_COUNT_WIDTH_PP(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .ce_i(ce),
    .start_i(start),
    .dat_ascii_i(dat_ascii),
    .dat_valid_i(dat_valid),
    .dat_ready_o(dat_ready),
    .dat_binary_o(dat_binary),
    .digits_o(digits),
    .busy_o(busy),
    .done_o(done),
    .err_o(err)
  );

  always #5 clk = ~clk;

  // Field-level reference: collect consumed bytes, evaluate the field at SOH
  int          m_phase = 0;   // 0 waiting, 1 collecting, 2 result pulse
  byte unsigned mq[$];
  logic [31:0] e_bin = '0;
  logic [3:0]  e_dig = '0;
  logic        e_err = 1'b0;

  function automatic void eval_field();
    longint v = 0;
    longint nv;
    int     n = 0;
    bit     e = 1'b0;
    foreach (mq[i]) begin
      if (mq[i] >= 8'h30 && mq[i] <= 8'h39) begin
        if (!e) begin
          nv = v * 10 + longint'(mq[i] - 8'h30);
          if (nv > 64'h0000_0000_FFFF_FFFF || n + 1 > 10) e = 1'b1;
          else begin
            v = nv;
            n++;
          end
        end
      end else begin
        e = 1'b1;
      end
    end
    if (n == 0) e = 1'b1;
    e_bin = e ? 32'd0 : v[31:0];
    e_dig = e ? 4'd0 : n[3:0];
    e_err = e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      e_bin   = '0;
      e_dig   = '0;
      e_err   = 1'b0;
      mq.delete();
    end else if (ce) begin
      case (m_phase)
        0: if (start) begin
             m_phase = 1;
             mq.delete();
           end
        1: if (dat_valid) begin
             if (dat_ascii == 8'h01) begin
               eval_field();
               m_phase = 2;
             end else begin
               mq.push_back(dat_ascii);
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("ready", 32'(dat_ready), 32'(m_phase == 1));
      cmp("busy",  32'(busy),      32'(m_phase != 0));
      cmp("done",  32'(done),      32'(m_phase == 2));
      cmp("binary", dat_binary, e_bin);
      cmp("digits", 32'(digits), 32'(e_dig));
      cmp("err",    32'(err),    32'(e_err));
    end
  end

  // Present one byte until consumed; inputs change only on falling edges
  task automatic send_byte(input logic [7:0] b, input int gap, input int ce_off, input bit st);
    bit acc;
    while ($urandom_range(0, 99) < gap) begin
      dat_valid = 1'b0;
      ce = ($urandom_range(0, 99) >= ce_off);
      @(negedge clk);
    end
    dat_valid = 1'b1;
    dat_ascii = b;
    start     = st;
    for (int n = 0; ; n++) begin
      ce  = ($urandom_range(0, 99) >= ce_off);
      acc = ce && dat_ready;
      @(negedge clk);
      if (acc) break;
      if (n > 200) begin
        n_fail++;
        $display("FAIL byte_accept_timeout: byte 0x%02h not consumed", b);
        break;
      end
    end
    start     = 1'b0;
    dat_valid = 1'b0;
    ce        = 1'b1;
  endtask

  task automatic send_field(input string s, input bit term, input int gap, input int ce_off,
                            input bit mid_start);
    ce    = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap, ce_off, mid_start && (i == 1));
    if (term) begin
      send_byte(8'h01, gap, ce_off, 1'b0);
      cmp("done_latency", 32'(done), 32'd1);
    end
  endtask

  task automatic field_lit(input string s, input logic [31:0] b, input logic [3:0] d, input logic e);
    send_field(s, 1'b1, 0, 0, 1'b0);
    cmp({"lit_bin_", s}, dat_binary, b);
    cmp({"lit_dig_", s}, 32'(digits), 32'(d));
    cmp({"lit_err_", s}, 32'(err), 32'(e));
    @(negedge clk);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    string s;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    cmp("rst_binary", dat_binary, 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_ready", 32'(dat_ready), 32'd0);
    rst    = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);

    field_lit("1234", 32'h0000_04D2, 4'd4, 1'b0);
    field_lit("4294967295", 32'hFFFF_FFFF, 4'd10, 1'b0);
    field_lit("4294967296", 32'h0, 4'd0, 1'b1);
    field_lit("12A3", 32'h0, 4'd0, 1'b1);
    field_lit("", 32'h0, 4'd0, 1'b1);
    field_lit("00000000007", 32'h0, 4'd0, 1'b1);
    field_lit("0000000007", 32'd7, 4'd10, 1'b0);

    // gaps, clock-enable stalls and a start pulse while accumulating
    send_field("56", 1'b1, 40, 30, 1'b1);
    cmp("lit_bin_56", dat_binary, 32'd56);
    cmp("lit_dig_56", 32'(digits), 32'd2);
    @(negedge clk);
    repeat (3) @(negedge clk);
    cmp("hold_bin_56", dat_binary, 32'd56);

    // reset between edges mid-field
    send_field("98", 1'b0, 0, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    cmp("mid_rst_binary", dat_binary, 32'd0);
    cmp("mid_rst_busy", 32'(busy), 32'd0);
    cmp("mid_rst_ready", 32'(dat_ready), 32'd0);
    cmp("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp("post_rst_done", 32'(done), 32'd0);
    field_lit("7", 32'd7, 4'd1, 1'b0);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 2))
        0: s = $sformatf("%0d", $urandom);
        1: s = $sformatf("%0d%0d", $urandom, $urandom_range(0, 9));
        default: begin
          s = "";
          for (int j = 0; j < int'($urandom_range(0, 12)); j++) begin
            if ($urandom_range(0, 99) < 8) s = $sformatf("%s%c", s, 8'h41 + 8'($urandom_range(0, 25)));
            else s = $sformatf("%s%c", s, 8'h30 + 8'($urandom_range(0, 9)));
          end
        end
      endcase
      send_field(s, 1'b1, int'($urandom_range(0, 40)), int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)));
      repeat (int'($urandom_range(1, 3))) @(negedge clk);
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
